uart_tx_buffered: RTL and testbench

Parametrised, buffered UART transmitter and successor to the fixed 8-bit single-shot transmitter. It accepts parallel words into an internal FIFO and serialises them LSB-first as start/data/optional-parity/stop frames. Baud rate comes from a programmable clock divider, and frames can use 1 or 2 stop bits. It sits between the host-side register/stream logic and the serial pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_buffered_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_buffered.sv | 138 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and width helpers
// used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int count_bits(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Host-side write stream into the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] p_data_tx;
  logic              data_valid_tx;
  logic              data_ready_tx;

  modport master (output p_data_tx, output data_valid_tx, input data_ready_tx);
  modport slave  (input p_data_tx, input data_valid_tx, output data_ready_tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data always shows the head word.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DWIDTH-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DWIDTH-1:0]             rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [count_bits(DEPTH)-1:0]  count
);
  localparam int AW = idx_bits(DEPTH);
  localparam int CW = count_bits(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; flushing the pointers and count empties it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first framing with optional parity,
// one or two stop bits and a programmable baud divisor latched per frame.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  uart_tx_buffered_if.slave                  wr,
  input  logic                               parity_en_tx,
  input  logic                               parity_type_tx,
  input  logic                               stop2_tx,
  input  logic [DIV_WIDTH-1:0]               baud_div,
  output logic                               s_data_tx,
  output logic                               busy_tx,
  output logic [count_bits(FIFO_DEPTH)-1:0]  fifo_count
);
  localparam int BW = idx_bits(DWIDTH);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  logic [2:0]           state;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_l;
  logic [BW-1:0]        bit_cnt;
  logic [DWIDTH-1:0]    shreg;
  logic                 par_en_l;
  logic                 par_bit;
  logic                 stop2_l;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DWIDTH-1:0]    fifo_rd_data;
  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;

  assign wr.data_ready_tx = ~fifo_full;

  assign bit_end   = (baud_cnt == div_l);
  assign last_stop = (state == S_STOP) && bit_end && (!stop2_l || bit_cnt == BW'(1));
  // A queued word starts either from idle or straight after the final stop bit.
  assign pop       = !fifo_empty && ((state == S_IDLE) || last_stop);

  uart_tx_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr.data_valid_tx && !fifo_full),
    .wr_data (wr.p_data_tx),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // NOTE: every register here updates with <= so all reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      s_data_tx <= 1'b1;
      busy_tx   <= 1'b0;
      baud_cnt  <= '0;
      div_l     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_l  <= 1'b0;
      par_bit   <= 1'b0;
      stop2_l   <= 1'b0;
    end else if (pop) begin
      state     <= S_START;
      s_data_tx <= 1'b0;
      busy_tx   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= fifo_rd_data;
      div_l     <= baud_div;
      par_en_l  <= parity_en_tx;
      stop2_l   <= stop2_tx;
      par_bit   <= (parity_type_tx == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
    end else if (state != S_IDLE) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          S_START: begin
            state     <= S_DATA;
            s_data_tx <= shreg[0];
            shreg     <= shreg >> 1;
          end
          S_DATA: begin
            if (bit_cnt == BW'(DWIDTH - 1)) begin
              bit_cnt <= '0;
              if (par_en_l) begin
                state     <= S_PARITY;
                s_data_tx <= par_bit;
              end else begin
                state     <= S_STOP;
                s_data_tx <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + BW'(1);
              s_data_tx <= shreg[0];
              shreg     <= shreg >> 1;
            end
          end
          S_PARITY: begin
            state     <= S_STOP;
            s_data_tx <= 1'b1;
          end
          S_STOP: begin
            // Reaching here on the last stop bit means the FIFO was empty.
            if (last_stop) begin
              state     <= S_IDLE;
              busy_tx   <= 1'b0;
              s_data_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: directed frames with literal expectations plus randomized
// traffic compared every cycle against a frame-level reference model.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        par_en, par_type, stop2;
  logic [15:0] div;
  logic        line8, busy8, line5, busy5;
  logic [2:0]  cnt8, cnt5;
  logic        c_zero = 1'b0;
  logic [15:0] div5 = 16'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_buffered_if #(.DWIDTH(8)) wr8 ();
  uart_tx_buffered_if #(.DWIDTH(5)) wr5 ();

  uart_tx_buffered #(.DWIDTH(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .wr(wr8),
    .parity_en_tx(par_en), .parity_type_tx(par_type), .stop2_tx(stop2),
    .baud_div(div), .s_data_tx(line8), .busy_tx(busy8), .fifo_count(cnt8)
  );

  uart_tx_buffered #(.DWIDTH(5), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut5 (
    .clk(clk), .rst(rst), .wr(wr5),
    .parity_en_tx(c_zero), .parity_type_tx(c_zero), .stop2_tx(c_zero),
    .baud_div(div5), .s_data_tx(line5), .busy_tx(busy5), .fifo_count(cnt5)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame as a list of timed bits) ----------------
  logic [7:0] m_q[$];
  logic       m_bits[$];
  int         m_len, m_cyc;
  bit         m_active = 0;
  bit         m_ok = 0;

  task automatic model_load(input logic [7:0] d);
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_bits.push_back(d[i]);
    if (par_en) begin
      // Even parity makes the total count of ones even; odd makes it odd.
      if (par_type == PAR_ODD) m_bits.push_back(($countones(d) % 2) == 0);
      else                     m_bits.push_back(($countones(d) % 2) == 1);
    end
    m_bits.push_back(1'b1);
    if (stop2) m_bits.push_back(1'b1);
    m_len    = int'(div) + 1;
    m_cyc    = 0;
    m_active = 1;
  endtask

  always @(posedge clk) begin
    bit         acc;
    logic [7:0] acc_d;
    acc   = wr8.data_valid_tx && (m_q.size() < DEPTH);
    acc_d = wr8.p_data_tx;
    if (rst) begin
      m_q.delete();
      m_bits.delete();
      m_active = 0;
      m_cyc    = 0;
    end else begin
      if (m_active) begin
        m_cyc++;
        if (m_cyc == m_len) begin
          m_cyc = 0;
          void'(m_bits.pop_front());
          if (m_bits.size() == 0) m_active = 0;
        end
      end
      if (!m_active && m_q.size() > 0) model_load(m_q.pop_front());
      if (acc) m_q.push_back(acc_d);
    end
    m_ok = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("line",  line8, m_active ? m_bits[0] : 1'b1);
      check("busy",  busy8, m_active);
      check("count", cnt8, m_q.size());
      check("ready", wr8.data_ready_tx, m_q.size() < DEPTH);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input logic [7:0] d, output int waited);
    waited = 0;
    wr8.p_data_tx     = d;
    wr8.data_valid_tx = 1'b1;
    while (!wr8.data_ready_tx && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) check("send_ready", wr8.data_ready_tx, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((busy8 || cnt8 != 3'd0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) check("drain", busy8, 1'b0);
  endtask

  task automatic capture(input int per, output logic [15:0] bits, output int nbusy, output int lead);
    int t = 0;
    bit seen = 0;
    bits = '0; nbusy = 0; lead = 0;
    while (t < 2000) begin
      if (busy8) begin
        seen = 1;
        if (nbusy % per == 0 && nbusy / per < 16) bits[nbusy/per] = line8;
        nbusy++;
      end else if (seen) begin
        break;
      end else begin
        lead++;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("capture_end", busy8, 1'b0);
  endtask

  task automatic busy_run(output int n);
    int t = 0;
    n = 0;
    while (!busy8 && t < 200) begin @(negedge clk); t++; end
    while (busy8 && t < 3000) begin n++; @(negedge clk); t++; end
    if (t >= 3000) check("busy_run_end", busy8, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    logic [8:0]  seq_line, seq_busy;
    int nb, lead, w, first_stall, run;

    wr8.p_data_tx = '0; wr8.data_valid_tx = 1'b0;
    wr5.p_data_tx = '0; wr5.data_valid_tx = 1'b0;
    par_en = 1'b0; par_type = PAR_EVEN; stop2 = 1'b0; div = 16'd3;

    repeat (3) @(negedge clk);
    check("rst_line",  line8, 1'b1);
    check("rst_busy",  busy8, 1'b0);
    check("rst_ready", wr8.data_ready_tx, 1'b1);
    check("rst_count", cnt8, 3'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 0xA5, 4 clocks per bit.
    send(8'hA5, w);
    wr8.data_valid_tx = 1'b0;
    capture(4, bits, nb, lead);
    check("a5_bits", bits[9:0], 10'b1101001010);
    check("a5_busy", nb, 40);
    check("a5_lead", lead, 1);

    // Parity on 0x07 (three ones).
    div = 16'd1; par_en = 1'b1; par_type = PAR_EVEN;
    send(8'h07, w); wr8.data_valid_tx = 1'b0;
    capture(2, bits, nb, lead);
    check("even_par", bits[9], 1'b1);
    check("even_stop", bits[10], 1'b1);
    check("even_len", nb, 22);
    par_type = PAR_ODD;
    send(8'h07, w); wr8.data_valid_tx = 1'b0;
    capture(2, bits, nb, lead);
    check("odd_par", bits[9], 1'b0);
    check("odd_len", nb, 22);
    stop2 = 1'b1;
    send(8'h07, w); wr8.data_valid_tx = 1'b0;
    capture(2, bits, nb, lead);
    check("stop2_len", nb, 24);
    par_en = 1'b0; stop2 = 1'b0;

    // Burst of six words into a four-deep FIFO.
    first_stall = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(8'(8'h30 + i), w);
          if (w > 0 && first_stall == 0) first_stall = i + 1;
        end
        wr8.data_valid_tx = 1'b0;
      end
      busy_run(run);
    join
    check("burst_first_stall", first_stall, 6);
    check("burst_no_gap", run, 120);
    wait_idle(500);

    // Divisor change mid-frame applies only from the next frame.
    div = 16'd3;
    fork
      begin
        send(8'h5A, w);
        send(8'hC3, w);
        wr8.data_valid_tx = 1'b0;
        repeat (8) @(negedge clk);
        div = 16'd1;
      end
      busy_run(run);
    join
    check("cfg_change_len", run, 60);
    wait_idle(500);

    // Reset mid-frame with two words still queued.
    div = 16'd3;
    send(8'h11, w); send(8'h22, w); send(8'h33, w);
    wr8.data_valid_tx = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_count", cnt8, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_line",  line8, 1'b1);
    check("mid_rst_busy",  busy8, 1'b0);
    check("mid_rst_count", cnt8, 3'd0);
    rst = 1'b0;
    nb = 0;
    repeat (100) begin @(negedge clk); if (busy8) nb++; end
    check("post_rst_silent", nb, 0);

    // baud_div=0: write coinciding with a pop at count 2.
    div = 16'd0;
    send(8'h81, w); send(8'h42, w); send(8'h24, w);
    wr8.data_valid_tx = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_pop_count", cnt8, 3'd2);
    wr8.p_data_tx = 8'h99; wr8.data_valid_tx = 1'b1;
    @(negedge clk);
    wr8.data_valid_tx = 1'b0;
    check("wr_pop_count", cnt8, 3'd2);
    check("wr_pop_start", line8, 1'b0);
    wait_idle(500);

    // Five-bit variant at one clock per bit: 0x16 -> 7-cycle frame.
    wr5.p_data_tx = 5'h16; wr5.data_valid_tx = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr5.data_valid_tx = 1'b0;
      seq_line[i] = line5;
      seq_busy[i] = busy5;
    end
    check("w5_line", seq_line, 9'b111011001);
    check("w5_busy", seq_busy, 9'b011111110);
    check("w5_count", cnt5, 3'd0);

    // Randomized traffic with configuration changing at arbitrary times.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        par_en   = 1'($urandom_range(0, 1));
        par_type = 1'($urandom_range(0, 1));
        stop2    = 1'($urandom_range(0, 1));
        div      = 16'($urandom_range(0, 3));
      end
      send(8'($urandom), w);
      if ($urandom_range(0, 1) == 1) begin
        wr8.data_valid_tx = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk);
      end
    end
    wr8.data_valid_tx = 1'b0;
    wait_idle(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
